// File: rtl/seq_muldiv.sv
// Iterative 16-bit unsigned mul (shift-add) / div (restoring); result 16 edges after accept, div-by-zero 1 edge.
// in_ready only in IDLE, result held in DONE until out_ready; SEQ_MULDIV_EARLY_EXIT_EN ends mul once multiplier bits run out.
module seq_muldiv #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] upper,
    output logic [WIDTH-1:0] lower,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             op_q, op_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] upper_q, upper_d;
    logic [WIDTH-1:0] lower_q, lower_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH-1:0] it_acc, it_lo;
    logic [WIDTH-1:0] mul_hi, mul_lo;
    logic             last_iter;
`ifdef SEQ_MULDIV_EARLY_EXIT_EN
    logic [WIDTH-1:0]   mrem_q, mrem_d;
    logic [2*WIDTH-1:0] aligned;
`endif

    // One iteration step: acc holds product-high / remainder, lo holds multiplier / dividend->quotient.
    always_comb begin
        mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        div_trial = {acc_q, lo_q[WIDTH-1]} - {1'b0, b_q};
        if (op_q) begin
            if (!div_trial[WIDTH]) begin
                it_acc = div_trial[WIDTH-1:0];
                it_lo  = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                it_acc = {acc_q[WIDTH-2:0], lo_q[WIDTH-1]};
                it_lo  = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            it_acc = mul_sum[WIDTH:1];
            it_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
        last_iter = (cnt_q == CNT_W'(WIDTH-1)) || (op_q && (b_q == '0));
`ifdef SEQ_MULDIV_EARLY_EXIT_EN
        // Skipped iterations would only shift right, so apply them in one go.
        aligned = {it_acc, it_lo} >> (CNT_W'(WIDTH-1) - cnt_q);
        mul_hi  = aligned[2*WIDTH-1:WIDTH];
        mul_lo  = aligned[WIDTH-1:0];
        if (!op_q && ((mrem_q >> 1) == '0))
            last_iter = 1'b1;
`else
        mul_hi = it_acc;
        mul_lo = it_lo;
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        b_d     = b_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        upper_d = upper_q;
        lower_d = lower_q;
        dbz_d   = dbz_q;
`ifdef SEQ_MULDIV_EARLY_EXIT_EN
        mrem_d  = mrem_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d    = op;
                    cnt_d   = '0;
                    acc_d   = '0;
                    b_d     = op ? operand2 : operand1;
                    lo_d    = op ? operand1 : operand2;
`ifdef SEQ_MULDIV_EARLY_EXIT_EN
                    mrem_d  = operand2;
`endif
                    state_d = BUSY;
                end
            end
            BUSY: begin
                acc_d = it_acc;
                lo_d  = it_lo;
                cnt_d = cnt_q + 1'b1;
`ifdef SEQ_MULDIV_EARLY_EXIT_EN
                mrem_d = mrem_q >> 1;
`endif
                if (last_iter) begin
                    state_d = DONE;
                    // Zero divisor leaves after one cycle with the dividend still untouched in lo_q.
                    if (op_q && (b_q == '0)) begin
                        upper_d = lo_q;
                        lower_d = '1;
                        dbz_d   = 1'b1;
                    end else if (op_q) begin
                        upper_d = it_acc;
                        lower_d = it_lo;
                        dbz_d   = 1'b0;
                    end else begin
                        upper_d = mul_hi;
                        lower_d = mul_lo;
                        dbz_d   = 1'b0;
                    end
                end
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            b_q     <= '0;
            acc_q   <= '0;
            lo_q    <= '0;
            upper_q <= '0;
            lower_q <= '0;
            dbz_q   <= 1'b0;
`ifdef SEQ_MULDIV_EARLY_EXIT_EN
            mrem_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            upper_q <= upper_d;
            lower_q <= lower_d;
            dbz_q   <= dbz_d;
`ifdef SEQ_MULDIV_EARLY_EXIT_EN
            mrem_q  <= mrem_d;
`endif
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign upper       = upper_q;
    assign lower       = lower_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_muldiv.sv
// Bench for seq_muldiv: directed and random mul/div against plain-arithmetic reference, latency and handshake.
module tb_seq_muldiv;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, op;
    logic [15:0] operand1, operand2;
    logic        out_valid, out_ready;
    logic [15:0] upper, lower;
    logic        div_by_zero;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seq_muldiv #(.WIDTH(16), .CNT_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .operand1   (operand1),
        .operand2   (operand2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .upper      (upper),
        .lower      (lower),
        .div_by_zero(div_by_zero)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int exp_latency(input logic o, input logic [15:0] b);
        int k;
        k = 0;
        if (o) return (b == 16'd0) ? 1 : 16;
`ifdef SEQ_MULDIV_EARLY_EXIT_EN
        for (int i = 0; i < 16; i++)
            if (b[i]) k = i;
        return k + 1;
`else
        return 16 + k;
`endif
    endfunction

    // Called right after a clock edge (+1); leaves the bench at the same phase.
    task automatic run_op(input logic o, input logic [15:0] a, input logic [15:0] b, input int hold);
        logic [31:0] p;
        logic [15:0] eu, el;
        logic        ed;
        int          lat, want_lat;
        p = 32'(a) * 32'(b);
        if (!o) begin
            eu = p[31:16]; el = p[15:0]; ed = 1'b0;
        end else if (b == 16'd0) begin
            eu = a; el = 16'hFFFF; ed = 1'b1;
        end else begin
            eu = a % b; el = a / b; ed = 1'b0;
        end
        want_lat = exp_latency(o, b);

        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1; op = o; operand1 = a; operand2 = b;
        @(posedge clk); #1;
        in_valid = 1'b0; op = 1'($urandom); operand1 = 16'($urandom); operand2 = 16'($urandom);
        chk("in_ready_after_accept", 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            @(posedge clk); #1;
            lat++;
            if (!out_valid) chk("in_ready_busy", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        if (!out_valid) lat = 999;
        chk("latency", 32'(lat), 32'(want_lat));
        chk("upper", 32'(upper), 32'(eu));
        chk("lower", 32'(lower), 32'(el));
        chk("div_by_zero", 32'(div_by_zero), 32'(ed));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_upper", 32'(upper), 32'(eu));
            chk("hold_lower", 32'(lower), 32'(el));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("handoff_out_valid", 32'(out_valid), 32'd0);
        chk("handoff_in_ready", 32'(in_ready), 32'd1);
        chk("after_upper", 32'(upper), 32'(eu));
        chk("after_lower", 32'(lower), 32'(el));
        chk("after_dbz", 32'(div_by_zero), 32'(ed));
    endtask

    initial begin
        logic        ro;
        logic [15:0] ra, rb;
        reset = 1'b1; in_valid = 1'b0; op = 1'b0; operand1 = '0; operand2 = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_upper", 32'(upper), 32'd0);
        chk("rst_lower", 32'(lower), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_op(1'b0, 16'h00FF, 16'h0101, 1);
        run_op(1'b0, 16'hFFFF, 16'hFFFF, 0);
        run_op(1'b0, 16'h1234, 16'h0003, 0);
        run_op(1'b0, 16'hBEEF, 16'h0000, 0);
        run_op(1'b1, 16'd1000, 16'd7, 0);
        run_op(1'b1, 16'd5, 16'd9, 0);
        run_op(1'b1, 16'hABCD, 16'h0000, 2);
        run_op(1'b1, 16'hFFFF, 16'h0001, 0);
        run_op(1'b0, 16'h8001, 16'h8000, 5);

        for (int n = 0; n < 40; n++) begin
            ro = 1'($urandom);
            ra = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = 16'd0;
                1:       rb = 16'($urandom_range(1, 15));
                default: rb = 16'($urandom);
            endcase
            run_op(ro, ra, rb, $urandom_range(0, 3));
        end

        // Abort a multiply with reset sampled on edge N+8.
        in_valid = 1'b1; op = 1'b0; operand1 = 16'hFFFF; operand2 = 16'hFFFF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_upper", 32'(upper), 32'd0);
        chk("abort_lower", 32'(lower), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        run_op(1'b1, 16'd100, 16'd10, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
